// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the logic/compare unit and its arbiter: opcode
// encodings, flag layout and FSM state encoding.
package logic_unit_arbiter_pkg;

  // Logic unit opcodes; anything above OPC_XNOR is illegal.
  localparam logic [3:0] OPC_AND  = 4'd0;
  localparam logic [3:0] OPC_OR   = 4'd1;
  localparam logic [3:0] OPC_NOR  = 4'd2;
  localparam logic [3:0] OPC_NOTA = 4'd3;
  localparam logic [3:0] OPC_NOTB = 4'd4;
  localparam logic [3:0] OPC_XOR  = 4'd5;
  localparam logic [3:0] OPC_XNOR = 4'd6;

  // Flag vector layout: {za, zb, eq, gt, lt}.
  localparam int FLAG_W  = 5;
  localparam int FLAG_ZA = 4;
  localparam int FLAG_ZB = 3;
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  // Arbiter FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a one-bit priority pointer. The pointer
// names the port that wins a tie and flips to the other port on every grant.
module logic_unit_arbiter_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);

  logic ptr_q;
  logic ptr_d;

  // Combinational grant and next pointer; a lone requester always wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    ptr_d = ptr_q;
    if (en && !rst) begin
      grant[0] = req_valid[0] && (!ptr_q || !req_valid[1]);
      grant[1] = req_valid[1] && ( ptr_q || !req_valid[0]);
    end
    if (grant[0]) begin
      ptr_d = 1'b1;
    end else if (grant[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational logic/compare unit between the execute path
// (port 0) and the branch/compare path (port 1). The winning request's
// operands are registered onto the unit, the result and flags are captured
// one cycle later, and returned on a valid/ready channel tagged with the id.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               OPC_W    = 4,
  parameter logic [OPC_W-1:0] LAST_OPC = OPC_W'(OPC_XNOR),
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OPC_W-1:0]  req0_opc,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OPC_W-1:0]  req1_opc,
  output logic [DATA_W-1:0] lu_op1,
  output logic [DATA_W-1:0] lu_op2,
  output logic [OPC_W-1:0]  lu_opc,
  input  logic [DATA_W-1:0] lu_out,
  input  logic [FLAG_W-1:0] lu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              rsp_illegal,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t              state_q,       state_d;
  logic [DATA_W-1:0]   lu_op1_q,      lu_op1_d;
  logic [DATA_W-1:0]   lu_op2_q,      lu_op2_d;
  logic [OPC_W-1:0]    lu_opc_q,      lu_opc_d;
  logic                rsp_valid_q,   rsp_valid_d;
  logic                rsp_id_q,      rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q,    rsp_data_d;
  logic [FLAG_W-1:0]   rsp_flags_q,   rsp_flags_d;
  logic                rsp_illegal_q, rsp_illegal_d;
  logic [CNT_W-1:0]    op_count_q,    op_count_d;
  logic [1:0]          grant;

  // Grants are only offered while idle; the arbiter masks them under reset.
  logic_unit_arbiter_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_IDLE),
    .req_valid (req_valid),
    .grant     (grant)
  );

  // Next-state logic: accept in IDLE, capture in EXEC, hand off in RESP.
  always_comb begin
    state_d       = state_q;
    lu_op1_d      = lu_op1_q;
    lu_op2_d      = lu_op2_q;
    lu_opc_d      = lu_opc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    op_count_d    = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant[0]) begin
          lu_op1_d = req0_op1;
          lu_op2_d = req0_op2;
          lu_opc_d = req0_opc;
          rsp_id_d = 1'b0;
          state_d  = ST_EXEC;
        end else if (grant[1]) begin
          lu_op1_d = req1_op1;
          lu_op2_d = req1_op2;
          lu_opc_d = req1_opc;
          rsp_id_d = 1'b1;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The unit has had a full cycle to settle on the registered operands.
        rsp_data_d    = lu_out;
        rsp_flags_d   = lu_flags;
        rsp_illegal_d = (lu_opc_q > LAST_OPC);
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      lu_op1_q      <= '0;
      lu_op2_q      <= '0;
      lu_opc_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      lu_op1_q      <= lu_op1_d;
      lu_op2_q      <= lu_op2_d;
      lu_opc_q      <= lu_opc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  assign req_ready   = grant;
  assign lu_op1      = lu_op1_q;
  assign lu_op2      = lu_op2_q;
  assign lu_opc      = lu_opc_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;
  assign busy        = (state_q != ST_IDLE);
  assign op_count    = op_count_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares the single combinational 16-bit logic/compare unit between two requesters: the instruction-execute path (port 0) and the branch/compare path (port 1).
- Arbitrates round-robin and registers the winner's operands onto the unit's inputs.
- Captures the unit's result and five flags, then returns them through a valid/ready response channel tagged with the requester id.

Parameters:
- DATA_W, 16, operand/result width.
- OPC_W, 4, opcode width.
- LAST_OPC, 6, highest legal opcode; above it the unit outputs 0 and the op is flagged illegal.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = port i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req0_op1, req0_op2  in  DATA_W each  port 0 operands.
- req0_opc  in  OPC_W  port 0 opcode.
- req1_op1, req1_op2  in  DATA_W each  port 1 operands.
- req1_opc  in  OPC_W  port 1 opcode.
- lu_op1, lu_op2  out  DATA_W each  registered operands to the logic unit.
- lu_opc  out  OPC_W  registered opcode to the logic unit.
- lu_out  in  DATA_W  logic unit result.
- lu_flags  in  5  {za,zb,eq,gt,lt} from the logic unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  DATA_W  captured result.
- rsp_flags  out  5  captured flags.
- rsp_illegal  out  1  opcode > LAST_OPC.
- busy  out  1  FSM not in IDLE.
- op_count  out  CNT_W  completed responses.

Behaviour:
- Reset (async, rst=1), all outputs and registers cleared: state=IDLE, rr_ptr=0, lu_op1/lu_op2/lu_opc=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, rsp_illegal=0, busy=0, op_count=0. req_ready=0 while rst is asserted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. req_ready[0] = valid0 & (rr_ptr==0 | !valid1); req_ready[1] = valid1 & (rr_ptr==1 | !valid0).
  - A handshake (req_valid[i] & req_ready[i]) latches that port's op1/op2/opc into lu_op1/lu_op2/lu_opc, latches id=i, sets rr_ptr = ~i, and moves to EXEC.
  - No valid request: stay in IDLE; registers hold.
- EXEC (exactly 1 cycle):
  - lu_* are stable; the unit settles combinationally.
  - At the clock edge: capture lu_out to rsp_data and lu_flags to rsp_flags, set rsp_illegal = (lu_opc > LAST_OPC), set rsp_valid=1, go to RESP.
  - req_ready=0.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_ready=1: rsp_valid clears, op_count increments (wraps from 2^CNT_W-1 to 0), go to IDLE.
  - req_ready=0.
- Latency: accept at edge T, rsp_valid high after edge T+1, earliest response accept at edge T+2. Back-to-back throughput is one op per 3 cycles.
- lu_* hold their last values after the op; there is no return to 0.
- Requester inputs are sampled only at the handshake edge; changes afterwards have no effect.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1. A lone requester always wins regardless of rr_ptr.
- An illegal opcode still goes through the unit and returns rsp_data=0 with the unit's flags, plus rsp_illegal=1. It counts in op_count.
- Reset mid-operation (EXEC or RESP) discards the op: rsp_valid drops immediately (async) and op_count is not incremented.
- busy = (state != IDLE).

Decomposition:
- Shared package, logic-unit constants: opcode localparams (AND=0, OR=1, NOR=2, NOTA=3, NOTB=4, XOR=5, XNOR=6), FLAG_W=5, flag bit indices (ZA=4, ZB=3, EQ=2, GT=1, LT=0), and the FSM state enum.
- Optional sub-module rr_arbiter2: the 2-way round-robin grant logic with pointer update.
- The logic unit itself stays instantiated at the next level up, not inside this block.

Test Plan:
- Reset, then port 0 requests op1=0x00F0, op2=0x0F0F, opc=0 (AND) → req_ready=2'b01 at cycle 0, rsp_valid at cycle 2 with rsp_id=0, rsp_data=0x0000, rsp_flags=5'b00001 (lt); op_count=1 after rsp_ready.
- Both ports continuously valid, port 0 XOR 0xAAAA^0x5555, port 1 NOTA 0x0000 → grant order 0,1,0,1; responses 0xFFFF (id 0) and 0xFFFF (id 1); no starvation.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, req_ready=0, busy=1; assert rsp_ready → IDLE next cycle.
- Port 1 opc=4'hF, op1=op2=0x0000 → rsp_data=0, rsp_illegal=1, rsp_flags=5'b11100 (za,zb,eq).
- Assert rst during RESP → rsp_valid, busy, op_count, lu_* reach 0 without a clock edge; rr_ptr=0, so port 0 wins the next simultaneous request.
- Preload 0xFFFF completions (or force op_count) and complete one more op → op_count wraps to 0x0000.
